// File: rtl/seq_divider_25_if.sv
// Handshake bundle for seq_divider_25.
//   Request side : in_valid, in_ready, dividend, divisor
//   Result side  : out_valid, out_ready, quotient, remainder, div_by_zero
// Modports:
//   master - the producer of operations and consumer of results (upstream/downstream)
//   slave  - the divider itself
interface seq_divider_25_if #(
    parameter int W = 25
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider_25.sv
// seq_divider_25
// Iterative restoring divider: one quotient bit per cycle, MSB first, by trial
// subtraction of the divisor from a W+1-bit partial remainder.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - seq_divider_25_if.slave
//          in_valid/in_ready/dividend/divisor : operation request (in_ready registered)
//          out_valid/out_ready                : result handshake (out_valid registered)
//          quotient/remainder/div_by_zero     : result, stable while out_valid=1 and
//                                               held after the handshake until the
//                                               next result is loaded
// Timing (cycle k = k-th clock period after the accept edge):
//   normal op      : out_valid in cycle W+1
//   divide by zero : out_valid in cycle 1 (quotient all ones, remainder = dividend)
module seq_divider_25 #(
    parameter int W = 25
) (
    input  logic              clk,
    input  logic              rst,
    seq_divider_25_if.slave   bus
);

    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [CW-1:0]   cnt;       // iteration index within BUSY
    logic [W-1:0]    dvd_sh;    // dividend, shifted left one bit per iteration
    logic [W-1:0]    dvs_q;     // latched divisor
    logic [W-1:0]    rem_q;     // partial remainder
    logic [W-1:0]    quo_sh;    // quotient bits collected so far

    logic [W:0]      r_ext;
    logic [W:0]      trial;
    logic            qbit;
    logic [W-1:0]    rem_nxt;
    logic [W-1:0]    quo_nxt;

    logic            accept;
    logic            out_fire;
    logic            last_iter;
    logic            dvs_zero;

    assign accept    = bus.in_valid && bus.in_ready;
    assign out_fire  = bus.out_valid && bus.out_ready;
    assign last_iter = (cnt == CW'(W - 1));
    assign dvs_zero  = (bus.divisor == '0);

    // One restoring step. When the trial goes negative r_ext < divisor, so the
    // kept value always fits back in W bits; likewise a non-negative trial is
    // below the divisor.
    assign r_ext   = {rem_q, dvd_sh[W-1]};
    assign trial   = r_ext - {1'b0, dvs_q};
    assign qbit    = ~trial[W];
    assign rem_nxt = qbit ? trial[W-1:0] : r_ext[W-1:0];
    assign quo_nxt = {quo_sh[W-2:0], qbit};

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = dvs_zero ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_fire) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake flags are registered copies of the next state, so they change
    // on the same edge as the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.in_ready  <= (state_nxt == IDLE);
            bus.out_valid <= (state_nxt == DONE);
        end
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt             <= '0;
            dvd_sh          <= '0;
            dvs_q           <= '0;
            rem_q           <= '0;
            quo_sh          <= '0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
        end else begin
            if (state == IDLE && accept) begin
                cnt             <= '0;
                dvd_sh          <= bus.dividend;
                dvs_q           <= bus.divisor;
                rem_q           <= '0;
                quo_sh          <= '0;
                bus.div_by_zero <= dvs_zero;
                // Divide by zero skips BUSY, so its result is loaded here.
                if (dvs_zero) begin
                    bus.quotient  <= '1;
                    bus.remainder <= bus.dividend;
                end
            end else if (state == BUSY) begin
                cnt    <= cnt + CW'(1);
                dvd_sh <= {dvd_sh[W-2:0], 1'b0};
                rem_q  <= rem_nxt;
                quo_sh <= quo_nxt;
                if (last_iter) begin
                    bus.quotient  <= quo_nxt;
                    bus.remainder <= rem_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_divider_25.sv
// Self-checking bench for seq_divider_25. Expected results come from a
// behavioural / and % model, queued when an operation is driven and popped
// when the divider presents its result.
module tb_seq_divider_25;

    localparam int W = 25;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    seq_divider_25_if #(.W(W)) bus();

    seq_divider_25 #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one operation; returns at the first negedge after the accept edge (cycle 1).
    task automatic send(input string tag, input logic [W-1:0] dvd, input logic [W-1:0] dvs);
        exp_t e;
        int   n = 0;
        while (bus.in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk({tag, "_in_ready_wait"}, 64'(bus.in_ready), 64'd1);
        bus.dividend = dvd;
        bus.divisor  = dvs;
        bus.in_valid = 1'b1;
        e.dz = (dvs == '0);
        e.q  = e.dz ? {W{1'b1}} : dvd / dvs;
        e.r  = e.dz ? dvd : dvd % dvs;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk({tag, "_in_ready_drop"}, 64'(bus.in_ready), 64'd0);
        chk({tag, "_dz_at_accept"}, 64'(bus.div_by_zero), 64'(e.dz));
    endtask

    task automatic get_result(input string tag, input int exp_lat, output exp_t e);
        int lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd1);
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd0, 64'd1);
            e = '{q: '0, r: '0, dz: 1'b0};
        end else begin
            e = sb.pop_front();
        end
        chk({tag, "_quotient"}, 64'(bus.quotient), 64'(e.q));
        chk({tag, "_remainder"}, 64'(bus.remainder), 64'(e.r));
        chk({tag, "_dbz"}, 64'(bus.div_by_zero), 64'(e.dz));
    endtask

    task automatic handshake(input string tag, input exp_t e);
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, "_post_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_post_ready"}, 64'(bus.in_ready), 64'd1);
        chk({tag, "_hold_q"}, 64'(bus.quotient), 64'(e.q));
        chk({tag, "_hold_r"}, 64'(bus.remainder), 64'(e.r));
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] dvd, input logic [W-1:0] dvs);
        exp_t e;
        send(tag, dvd, dvs);
        get_result(tag, (dvs == '0) ? 1 : W + 1, e);
        handshake(tag, e);
    endtask

    initial begin
        exp_t         e;
        logic [W-1:0] a;
        logic [W-1:0] b;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_quotient", 64'(bus.quotient), 64'd0);
        chk("rst_remainder", 64'(bus.remainder), 64'd0);
        chk("rst_dbz", 64'(bus.div_by_zero), 64'd0);
        rst = 1'b0;
        chk("rel_in_ready_before_edge", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("rel_in_ready_after_edge", 64'(bus.in_ready), 64'd1);

        // Main function and boundaries
        run_op("t1_1000_7", 25'd1000, 25'd7);
        run_op("t2_max_1", 25'h1FFFFFF, 25'd1);
        run_op("t2_max_max", 25'h1FFFFFF, 25'h1FFFFFF);
        run_op("t3_div0", 25'd5, 25'd0);
        run_op("t3_9_3", 25'd9, 25'd3);
        run_op("t4_3_10", 25'd3, 25'd10);
        run_op("t4_0_4", 25'd0, 25'd4);

        for (int i = 0; i < 6; i++) begin
            a = W'($urandom);
            b = W'($urandom) >> $urandom_range(0, W - 1);
            run_op($sformatf("rnd%0d", i), a, b);
        end

        // Backpressure: result and flags hold, new requests ignored
        send("t5_bp", 25'd1000, 25'd7);
        get_result("t5_bp", W + 1, e);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = (i % 2 == 0);
            bus.dividend = W'($urandom);
            bus.divisor  = W'($urandom);
            @(negedge clk);
            chk("t5_hold_valid", 64'(bus.out_valid), 64'd1);
            chk("t5_hold_in_ready", 64'(bus.in_ready), 64'd0);
            chk("t5_hold_q", 64'(bus.quotient), 64'(e.q));
            chk("t5_hold_r", 64'(bus.remainder), 64'(e.r));
        end
        bus.in_valid = 1'b0;
        handshake("t5_bp", e);
        @(negedge clk);
        chk("t5_single_hs", 64'(bus.out_valid), 64'd0);

        // Reset in the middle of BUSY
        send("t6_abort", 25'd123456, 25'd789);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("t6_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("t6_rst_quotient", 64'(bus.quotient), 64'd0);
        chk("t6_rst_remainder", 64'(bus.remainder), 64'd0);
        chk("t6_rst_dbz", 64'(bus.div_by_zero), 64'd0);
        void'(sb.pop_back());
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("t6_rel_in_ready", 64'(bus.in_ready), 64'd1);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) chk("t6_stale_valid", 64'(bus.out_valid), 64'd0);
        end
        chk("t6_no_stale_valid", 64'(bus.out_valid), 64'd0);
        run_op("t6_100_9", 25'd100, 25'd9);

        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
